gpu_mem_responder: RTL and testbench

- Parametrised, synthesizable memory responder serving the gpu's per-channel valid/ready memory interface.
- Successor to the single-cycle bench memory model. Adds:
  - configurable response latency
  - a limited number of physical access ports, shared by round-robin arbitration
  - a backdoor load/readback port
  - an access counter
- One instance serves program memory (read-only use); another serves data memory.

---
 rtl/gpu_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_gpu_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_responder.sv
// Multi-channel valid/ready memory responder: per-requester FSMs, round-robin
// arbitration onto a limited number of access ports, backdoor port, access counter.
module gpu_mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_PORTS    = 2,
  parameter int LATENCY      = 1,
  parameter int CNT_BITS     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready,
  input  logic                              bd_we,
  input  logic [ADDR_BITS-1:0]              bd_addr,
  input  logic [DATA_BITS-1:0]              bd_wdata,
  output logic [DATA_BITS-1:0]              bd_rdata,
  output logic [CNT_BITS-1:0]               access_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int NR    = 2 * NUM_CHANNELS;
  localparam int PW    = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW    = $clog2(NR + 1);
  localparam int TW    = CNT_BITS + SW;

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_WAIT, S_RESP, S_DRAIN} state_t;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [NR-1:0]        w_valid;
  logic [NR-1:0]        w_pend;
  logic [NR-1:0]        w_grant;
  logic [NR-1:0]        w_resp;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        w_rr_next;
  logic [PW-1:0]        w_idx;
  int                   w_ngrant;
  logic [CNT_BITS-1:0]  r_count;
  logic [SW-1:0]        w_nresp;
  logic [TW-1:0]        w_count_sum;
  logic [CNT_BITS-1:0]  w_count_next;

  // Requester index order: reads 0..N-1, then writes N..2N-1.
  assign w_valid = {write_valid, read_valid};

  // Scan from rr_ptr with wrap, granting up to NUM_PORTS pending requesters.
  always_comb begin
    w_grant   = '0;
    w_rr_next = r_rr_ptr;
    w_ngrant  = 0;
    w_idx     = '0;
    for (int k = 0; k < NR; k++) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % NR);
      if (w_pend[w_idx] && (w_ngrant < NUM_PORTS)) begin
        w_grant[w_idx] = 1'b1;
        w_ngrant       = w_ngrant + 1;
        w_rr_next      = PW'((int'(w_idx) + 1) % NR);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rr_ptr <= '0;
    else       r_rr_ptr <= w_rr_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_req
      state_t        r_state;
      state_t        w_state_next;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_next;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
          S_IDLE:  if (w_valid[gi]) w_state_next = S_PEND;
          S_PEND: begin
            if (!w_valid[gi]) begin
              w_state_next = S_IDLE;
            end else if (w_grant[gi]) begin
              if (LATENCY == 1) begin
                w_state_next = S_RESP;
              end else begin
                w_state_next = S_WAIT;
                w_cnt_next   = CW'(LATENCY - 1);
              end
            end
          end
          S_WAIT: begin
            if (r_cnt == '0) w_state_next = S_RESP;
            else             w_cnt_next   = r_cnt - 1'b1;
          end
          S_RESP:  w_state_next = S_DRAIN;
          // Held valid after completion parks here so it is never serviced twice.
          S_DRAIN: if (!w_valid[gi]) w_state_next = S_IDLE;
          default: w_state_next = S_IDLE;
        endcase
      end

      assign w_pend[gi] = (r_state == S_PEND) && w_valid[gi];
      assign w_resp[gi] = (r_state == S_RESP);
    end

    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_rd
      logic [DATA_BITS-1:0] r_rdata;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_rdata <= '0;
        else if (w_grant[gi]) r_rdata <= r_mem[read_address[gi*ADDR_BITS +: ADDR_BITS]];
      end

      assign read_data[gi*DATA_BITS +: DATA_BITS] = r_rdata;
    end
  endgenerate

  // Later assignments win: higher write index over lower, backdoor over all.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_grant[NUM_CHANNELS + c])
        r_mem[write_address[c*ADDR_BITS +: ADDR_BITS]] <= write_data[c*DATA_BITS +: DATA_BITS];
    end
    if (bd_we) r_mem[bd_addr] <= bd_wdata;
  end

  always_comb begin
    w_nresp = '0;
    for (int k = 0; k < NR; k++) w_nresp = w_nresp + SW'(w_resp[k]);
    w_count_sum  = TW'(r_count) + TW'(w_nresp);
    w_count_next = (w_count_sum > TW'({CNT_BITS{1'b1}})) ? {CNT_BITS{1'b1}}
                                                          : w_count_sum[CNT_BITS-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_count <= '0;
    else       r_count <= w_count_next;
  end

  assign read_ready   = w_resp[NUM_CHANNELS-1:0];
  assign write_ready  = w_resp[NR-1:NUM_CHANNELS];
  assign bd_rdata     = r_mem[bd_addr];
  assign access_count = r_count;

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Directed bench for gpu_mem_responder: two instances (fast/wide and slow/single-port),
// read responses checked against a per-channel scoreboard of expected data and cycle.
module tb_gpu_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] cyc;
  } sb_t;

  localparam logic [31:0] ANY = 32'hFFFF_FFFF;

  sb_t q_a [4][$];
  sb_t q_b [4][$];
  logic [7:0] ma [256];
  logic [7:0] mb [256];
  int acc [4];
  int exp_c [4] = '{7, 10, 15, 22};

  // Instance A: LATENCY=1, NUM_PORTS=2, 16-bit counter
  logic        reset_a;
  logic [3:0]  read_valid_a, read_ready_a, write_valid_a, write_ready_a;
  logic [31:0] read_address_a, read_data_a, write_address_a, write_data_a;
  logic        bd_we_a;
  logic [7:0]  bd_addr_a, bd_wdata_a, bd_rdata_a;
  logic [15:0] access_count_a;

  // Instance B: LATENCY=4, NUM_PORTS=1, 4-bit counter
  logic        reset_b;
  logic [3:0]  read_valid_b, read_ready_b, write_valid_b, write_ready_b;
  logic [31:0] read_address_b, read_data_b, write_address_b, write_data_b;
  logic        bd_we_b;
  logic [7:0]  bd_addr_b, bd_wdata_b, bd_rdata_b;
  logic [3:0]  access_count_b;

  gpu_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .NUM_PORTS(2),
                      .LATENCY(1), .CNT_BITS(16)) u_a (
    .clk(clk), .reset(reset_a),
    .read_valid(read_valid_a), .read_address(read_address_a),
    .read_ready(read_ready_a), .read_data(read_data_a),
    .write_valid(write_valid_a), .write_address(write_address_a),
    .write_data(write_data_a), .write_ready(write_ready_a),
    .bd_we(bd_we_a), .bd_addr(bd_addr_a), .bd_wdata(bd_wdata_a), .bd_rdata(bd_rdata_a),
    .access_count(access_count_a)
  );

  gpu_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .NUM_PORTS(1),
                      .LATENCY(4), .CNT_BITS(4)) u_b (
    .clk(clk), .reset(reset_b),
    .read_valid(read_valid_b), .read_address(read_address_b),
    .read_ready(read_ready_b), .read_data(read_data_b),
    .write_valid(write_valid_b), .write_address(write_address_b),
    .write_data(write_data_b), .write_ready(write_ready_b),
    .bd_we(bd_we_b), .bd_addr(bd_addr_b), .bd_wdata(bd_wdata_b), .bd_rdata(bd_rdata_b),
    .access_count(access_count_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write_a(input logic [7:0] a, input logic [7:0] d);
    bd_we_a = 1'b1; bd_addr_a = a; bd_wdata_a = d; ma[a] = d;
    tick();
    bd_we_a = 1'b0;
  endtask

  task automatic bd_write_b(input logic [7:0] a, input logic [7:0] d);
    bd_we_b = 1'b1; bd_addr_b = a; bd_wdata_b = d; mb[a] = d;
    tick();
    bd_we_b = 1'b0;
  endtask

  // All four channels of B read together; with one port they complete one per cycle
  // in scan order starting from channel 'first'.
  task automatic round_b(input int first);
    int c0;
    c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      int ch;
      ch = (first + j) % 4;
      q_b[ch].push_back('{data: mb[16 + ch], cyc: 32'(c0 + 6 + j)});
    end
    read_valid_b = 4'hF;
    repeat (10) tick();
    read_valid_b = 4'h0;
    tick();
  endtask

  // Response monitor: every ready pulse must match the head of that channel's queue.
  always @(negedge clk) begin
    sb_t e;
    for (int ch = 0; ch < 4; ch++) begin
      if (read_ready_a[ch] === 1'b1) begin
        chk("a_rd_expected", 64'(q_a[ch].size() > 0), 64'd1);
        if (q_a[ch].size() > 0) begin
          e = q_a[ch].pop_front();
          chk("a_rd_data", 64'(read_data_a[ch*8 +: 8]), 64'(e.data));
          if (e.cyc != ANY) chk("a_rd_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (read_ready_b[ch] === 1'b1) begin
        chk("b_rd_expected", 64'(q_b[ch].size() > 0), 64'd1);
        if (q_b[ch].size() > 0) begin
          e = q_b[ch].pop_front();
          chk("b_rd_data", 64'(read_data_b[ch*8 +: 8]), 64'(e.data));
          if (e.cyc != ANY) chk("b_rd_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    int c0;
    int pending;
    reset_a = 1'b1; reset_b = 1'b1;
    read_valid_a = '0; read_address_a = '0; write_valid_a = '0;
    write_address_a = '0; write_data_a = '0;
    bd_we_a = 1'b0; bd_addr_a = '0; bd_wdata_a = '0;
    read_valid_b = '0; read_address_b = '0; write_valid_b = '0;
    write_address_b = '0; write_data_b = '0;
    bd_we_b = 1'b0; bd_addr_b = '0; bd_wdata_b = '0;
    for (int i = 0; i < 256; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; end
    for (int i = 0; i < 4; i++) acc[i] = 0;
    repeat (2) tick();

    chk("a_rst_rd_ready", 64'(read_ready_a), 64'd0);
    chk("a_rst_wr_ready", 64'(write_ready_a), 64'd0);
    chk("a_rst_rd_data", 64'(read_data_a), 64'd0);
    chk("a_rst_count", 64'(access_count_a), 64'd0);
    chk("b_rst_rd_ready", 64'(read_ready_b), 64'd0);
    chk("b_rst_count", 64'(access_count_b), 64'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // 2x2 matmul: thread i computes C[i/2][i%2] with 4 reads and 1 write
    for (int i = 0; i < 4; i++) begin
      bd_write_a(8'(i), 8'(i + 1));
      bd_write_a(8'(4 + i), 8'(i + 1));
    end
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) begin
        int r, cc, k;
        logic [7:0] ad;
        r = i / 2; cc = i % 2; k = s / 2;
        ad = (s % 2 == 0) ? 8'(r * 2 + k) : 8'(4 + k * 2 + cc);
        read_address_a[i*8 +: 8] = ad;
        q_a[i].push_back('{data: ma[ad], cyc: ANY});
        if (s % 2 == 1) acc[i] = acc[i] + int'(ma[r * 2 + k]) * int'(ma[ad]);
      end
      read_valid_a = 4'hF;
      repeat (6) tick();
      read_valid_a = 4'h0;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      write_address_a[i*8 +: 8] = 8'(8 + i);
      write_data_a[i*8 +: 8]    = 8'(acc[i]);
      ma[8 + i]                 = 8'(acc[i]);
    end
    write_valid_a = 4'hF;
    repeat (6) tick();
    write_valid_a = 4'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bd_addr_a = 8'(8 + i);
      #1;
      chk("a_matmul_c", 64'(bd_rdata_a), 64'(exp_c[i]));
    end
    chk("a_matmul_count", 64'(access_count_a), 64'd20);

    // Same-cycle read and write of addr 9: read sees the old value
    bd_write_a(8'd9, 8'h11);
    c0 = cyc;
    read_address_a[7:0] = 8'd9; write_address_a[7:0] = 8'd9; write_data_a[7:0] = 8'h5A;
    q_a[0].push_back('{data: 8'h11, cyc: 32'(c0 + 2)});
    read_valid_a = 4'b0001; write_valid_a = 4'b0001;
    repeat (2) tick();
    chk("a_wr_ready_lat1", 64'(write_ready_a), 64'b0001);
    read_valid_a = 4'h0; write_valid_a = 4'h0;
    ma[9] = 8'h5A;
    tick();
    bd_addr_a = 8'd9;
    #1;
    chk("a_rw_new_val", 64'(bd_rdata_a), 64'h5A);
    c0 = cyc;
    read_address_a[15:8] = 8'd9;
    q_a[1].push_back('{data: ma[9], cyc: 32'(c0 + 2)});
    read_valid_a = 4'b0010;
    repeat (2) tick();
    read_valid_a = 4'h0;
    tick();

    // Two writes to the same address in one cycle: higher index wins
    write_address_a[15:8] = 8'd20; write_data_a[15:8] = 8'h33;
    write_address_a[23:16] = 8'd20; write_data_a[23:16] = 8'h44;
    write_valid_a = 4'b0110;
    repeat (2) tick();
    chk("a_wr_pair_ready", 64'(write_ready_a), 64'b0110);
    write_valid_a = 4'h0;
    tick();
    bd_addr_a = 8'd20;
    #1;
    chk("a_wr_hi_wins", 64'(bd_rdata_a), 64'h44);

    // Backdoor write on the grant edge beats the functional write
    write_address_a[31:24] = 8'd21; write_data_a[31:24] = 8'h55;
    write_valid_a = 4'b1000;
    tick();
    bd_we_a = 1'b1; bd_addr_a = 8'd21; bd_wdata_a = 8'h66;
    tick();
    bd_we_a = 1'b0;
    chk("a_wr_bd_ready", 64'(write_ready_a), 64'b1000);
    write_valid_a = 4'h0;
    tick();
    #1;
    chk("a_bd_wins", 64'(bd_rdata_a), 64'h66);
    chk("a_count_total", 64'(access_count_a), 64'd26);

    // LATENCY=4: single read, valid held 3 cycles past the pulse
    bd_write_b(8'd5, 8'd2);
    for (int i = 0; i < 4; i++) bd_write_b(8'(16 + i), 8'(8'hA0 + i));
    c0 = cyc;
    read_address_b[7:0] = 8'd5;
    q_b[0].push_back('{data: mb[5], cyc: 32'(c0 + 6)});
    read_valid_b = 4'b0001;
    repeat (9) tick();
    read_valid_b = 4'h0;
    repeat (3) tick();
    chk("b_count_single", 64'(access_count_b), 64'd1);

    // Three reads queued behind one port; reset while they are in flight
    read_address_b[15:8] = 8'd5; read_address_b[23:16] = 8'd5;
    read_valid_b = 4'b0111;
    repeat (6) tick();
    chk("b_first_from_ptr1", 64'(read_ready_b), 64'b0010);
    chk("b_ch1_data", 64'(read_data_b[15:8]), 64'd2);
    reset_b = 1'b1;
    read_valid_b = 4'h0;
    #1;
    chk("b_async_rst_ready", 64'(read_ready_b), 64'd0);
    chk("b_async_rst_data", 64'(read_data_b), 64'd0);
    chk("b_async_rst_count", 64'(access_count_b), 64'd0);
    tick();
    reset_b = 1'b0;
    repeat (4) tick();
    chk("b_post_rst_ready", 64'(read_ready_b), 64'd0);
    chk("b_post_rst_count", 64'(access_count_b), 64'd0);
    bd_addr_b = 8'd5;
    #1;
    chk("b_mem_retained", 64'(bd_rdata_b), 64'd2);

    // Contention: order 0,1,2,3 from rr_ptr=0; one read on ch1 moves rr_ptr to 2
    for (int i = 0; i < 4; i++) read_address_b[i*8 +: 8] = 8'(16 + i);
    round_b(0);
    c0 = cyc;
    q_b[1].push_back('{data: mb[17], cyc: 32'(c0 + 6)});
    read_valid_b = 4'b0010;
    repeat (7) tick();
    read_valid_b = 4'h0;
    tick();
    round_b(2);
    chk("b_count_9", 64'(access_count_b), 64'd9);
    repeat (3) round_b(2);
    chk("b_count_sat", 64'(access_count_b), 64'd15);

    pending = 0;
    for (int i = 0; i < 4; i++) pending = pending + q_a[i].size() + q_b[i].size();
    chk("sb_drained", 64'(pending), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
